// File: rtl/thresholding_cfg_loader_if.sv
// Bundle of the load stream, readback request/response and cfg target port.
// master = the loader (cfg initiator), slave = host stream plus thresholding target.
interface thresholding_cfg_loader_if #(
  parameter int K      = 10,
  parameter int N      = 4,
  parameter int CNL_W  = 3,
  parameter int ADDR_W = 7
);
  logic              reload;
  logic              ld_vld;
  logic              ld_rdy;
  logic [K-1:0]      ld_dat;
  logic              ld_done;
  logic              ld_err;
  logic              rb_vld;
  logic              rb_rdy;
  logic [CNL_W-1:0]  rb_cnl;
  logic [N-1:0]      rb_idx;
  logic              rd_vld;
  logic              rd_rdy;
  logic [K-1:0]      rd_dat;
  logic              cfg_en;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_a;
  logic [K-1:0]      cfg_d;
  logic              cfg_rack;
  logic [K-1:0]      cfg_q;

  modport master (
    input  reload, ld_vld, ld_dat, rb_vld, rb_cnl, rb_idx, rd_rdy, cfg_rack, cfg_q,
    output ld_rdy, ld_done, ld_err, rb_rdy, rd_vld, rd_dat, cfg_en, cfg_we, cfg_a, cfg_d
  );

  modport slave (
    output reload, ld_vld, ld_dat, rb_vld, rb_cnl, rb_idx, rd_rdy, cfg_rack, cfg_q,
    input  ld_rdy, ld_done, ld_err, rb_rdy, rd_vld, rd_dat, cfg_en, cfg_we, cfg_a, cfg_d
  );
endinterface

// File: rtl/thresholding_cfg_loader.sv
// Loads all C*(2^N-1) thresholds over the cfg port, then serves credit-limited readback.
// Optional macro THRESHOLDING_CFG_ORDER_CHECK_EN adds the per-channel ordering check on ld_err.
module thresholding_cfg_loader #(
  parameter int K        = 10,
  parameter int N        = 4,
  parameter int C        = 6,
  parameter int PE       = 2,
  parameter int SIGNED   = 0,
  parameter int FPARG    = 0,
  parameter int RB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  thresholding_cfg_loader_if.master   bus
);
  localparam int CF     = C / PE;
  localparam int CNL_W  = $clog2(C);
  localparam int PE_W   = $clog2(PE);
  localparam int CF_W   = $clog2(CF);
  localparam int ADDR_W = N + PE_W + CF_W;
  localparam int CR_W   = $clog2(RB_DEPTH + 1);
  localparam int PTR_W  = $clog2(RB_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

  // Shifting by the field offsets drops zero-width cf/pe fields naturally.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CNL_W-1:0] cnl, input logic [N-1:0] idx);
    int c;
    c = int'(cnl);
    return (ADDR_W'(c / PE) << (N + PE_W)) | (ADDR_W'(c % PE) << N) | ADDR_W'(idx);
  endfunction

  function automatic logic [K-1:0] order_key(input logic [K-1:0] v);
    logic [K-1:0] key;
    key = v;
    if (SIGNED != 0) begin
      key[K-1] = ~v[K-1];
      if (FPARG != 0 && v[K-1]) key[K-2:0] = ~v[K-2:0];
    end
    return key;
  endfunction

  state_t             state_q, state_d;
  logic [CNL_W-1:0]   lcnl_q, lcnl_d;
  logic [N-1:0]       lidx_q, lidx_d;
  logic               cfg_en_q, cfg_en_d, cfg_we_q, cfg_we_d;
  logic [ADDR_W-1:0]  cfg_a_q, cfg_a_d;
  logic [K-1:0]       cfg_d_q, cfg_d_d;
  logic               ld_rdy_q, ld_rdy_d, rb_rdy_q, rb_rdy_d, ld_done_q, ld_done_d;
  logic [CR_W-1:0]    credits_q, credits_d, inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [K-1:0]       fifo_mem [RB_DEPTH];

  logic ld_acc, rb_acc, rb_oor, rd_issue, rack_ok, pop;

  assign ld_acc   = bus.ld_vld && ld_rdy_q;
  assign rb_acc   = bus.rb_vld && rb_rdy_q;
  assign rb_oor   = (int'(bus.rb_cnl) >= C) || (bus.rb_idx == {N{1'b1}});
  assign rd_issue = rb_acc && !rb_oor;
  // A stray acknowledge with nothing outstanding must not reach the FIFO.
  assign rack_ok  = bus.cfg_rack && (inflight_q != '0);
  assign pop      = (count_q != '0) && bus.rd_rdy;

  always_comb begin
    state_d  = state_q;
    lcnl_d   = lcnl_q;
    lidx_d   = lidx_q;
    cfg_en_d = 1'b0;
    cfg_we_d = 1'b0;
    cfg_a_d  = cfg_a_q;
    cfg_d_d  = cfg_d_q;
    case (state_q)
      S_LOAD: begin
        if (ld_acc) begin
          cfg_en_d = 1'b1;
          cfg_we_d = 1'b1;
          cfg_a_d  = addr_of(lcnl_q, lidx_q);
          cfg_d_d  = bus.ld_dat;
          if (lidx_q == N'(2 ** N - 2)) begin
            lidx_d = '0;
            if (lcnl_q == CNL_W'(C - 1)) begin
              lcnl_d  = '0;
              state_d = S_RUN;
            end else begin
              lcnl_d = lcnl_q + 1'b1;
            end
          end else begin
            lidx_d = lidx_q + 1'b1;
          end
        end
        if (bus.reload) begin
          lidx_d  = '0;
          lcnl_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (rd_issue) begin
          cfg_en_d = 1'b1;
          cfg_a_d  = addr_of(bus.rb_cnl, bus.rb_idx);
        end
        if (bus.reload) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = S_LOAD;
          lcnl_d  = '0;
          lidx_d  = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase

    credits_d  = credits_q + CR_W'(rd_issue) - CR_W'(pop);
    inflight_d = inflight_q + CR_W'(rd_issue) - CR_W'(rack_ok);
    count_d    = count_q + CR_W'(rack_ok) - CR_W'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (rack_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(RB_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_W'(RB_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    ld_rdy_d  = (state_d == S_LOAD);
    rb_rdy_d  = (state_d == S_RUN) && (credits_d < CR_W'(RB_DEPTH));
    // Rises one cycle after the final write, falls as LOAD is re-entered.
    ld_done_d = (state_q != S_LOAD) && (state_d != S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      lcnl_q     <= '0;
      lidx_q     <= '0;
      cfg_en_q   <= 1'b0;
      cfg_we_q   <= 1'b0;
      cfg_a_q    <= '0;
      cfg_d_q    <= '0;
      ld_rdy_q   <= 1'b0;
      rb_rdy_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      credits_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lcnl_q     <= lcnl_d;
      lidx_q     <= lidx_d;
      cfg_en_q   <= cfg_en_d;
      cfg_we_q   <= cfg_we_d;
      cfg_a_q    <= cfg_a_d;
      cfg_d_q    <= cfg_d_d;
      ld_rdy_q   <= ld_rdy_d;
      rb_rdy_q   <= rb_rdy_d;
      ld_done_q  <= ld_done_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rack_ok) fifo_mem[wr_ptr_q] <= bus.cfg_q;
  end

  assign bus.cfg_en  = cfg_en_q;
  assign bus.cfg_we  = cfg_we_q;
  assign bus.cfg_a   = cfg_a_q;
  assign bus.cfg_d   = cfg_d_q;
  assign bus.ld_rdy  = ld_rdy_q;
  assign bus.rb_rdy  = rb_rdy_q;
  assign bus.ld_done = ld_done_q;
  assign bus.rd_vld  = (count_q != '0);
  assign bus.rd_dat  = fifo_mem[rd_ptr_q];

`ifdef THRESHOLDING_CFG_ORDER_CHECK_EN
  logic         ld_err_q, ld_err_d, reload_acc;
  logic [K-1:0] prev_key_q, prev_key_d, cur_key;

  assign reload_acc = bus.reload && (state_q != S_DRAIN);

  // Index 0 starts a new channel, so it is never compared with the previous key.
  always_comb begin
    cur_key    = order_key(bus.ld_dat);
    ld_err_d   = ld_err_q;
    prev_key_d = prev_key_q;
    if (ld_acc) begin
      prev_key_d = cur_key;
      if (lidx_q != '0 && cur_key < prev_key_q) ld_err_d = 1'b1;
    end
    if (reload_acc) ld_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err_q   <= 1'b0;
      prev_key_q <= '0;
    end else begin
      ld_err_q   <= ld_err_d;
      prev_key_q <= prev_key_d;
    end
  end

  assign bus.ld_err = ld_err_q;
`else
  assign bus.ld_err = 1'b0;
`endif
endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed bench for thresholding_cfg_loader: scoreboard queues filled at accept time, popped by a monitor.
module tb_thresholding_cfg_loader;
  localparam int K = 10, N = 4, C = 6, PE = 2, RB_DEPTH = 4, LAT = 3;
  localparam int CNL_W = 3, ADDR_W = 7, TPC = 15, NTH = C * TPC;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [K-1:0]      d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thresholding_cfg_loader_if #(.K(K), .N(N), .CNL_W(CNL_W), .ADDR_W(ADDR_W)) bus ();

  thresholding_cfg_loader #(
    .K(K), .N(N), .C(C), .PE(PE), .SIGNED(0), .FPARG(0), .RB_DEPTH(RB_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Thresholding target: write storage and a fixed-latency in-order read pipe.
  logic [K-1:0]   tmem [2 ** ADDR_W];
  logic [LAT-1:0] rack_pipe;
  logic [K-1:0]   q_pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      rack_pipe <= '0;
    end else begin
      rack_pipe <= {rack_pipe[LAT-2:0], bus.cfg_en && !bus.cfg_we};
      q_pipe[0] <= tmem[bus.cfg_a];
      for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
      if (bus.cfg_en && bus.cfg_we) tmem[bus.cfg_a] <= bus.cfg_d;
    end
  end
  assign bus.cfg_rack = rack_pipe[LAT-1];
  assign bus.cfg_q    = q_pipe[LAT-1];

  int n_vec = 0, n_err = 0, cyc = 0;
  int tb_pos = 0, rb_k = 0;
  int wr_count = 0, first_wr_cyc = 0, last_wr_cyc = 0, ld_done_rise_cyc = 0;
  int rd_issued = 0, rack_cnt = 0, last_rack_cyc = 0, pop_cnt = 0, seen35 = -1;
  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_ra[$];
  logic [K-1:0]      exp_rd[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [K-1:0] val(input int pos);
    return K'(pos * 7 + 11);
  endfunction

  // cf occupies bits 6:5, pe bit 4, idx bits 3:0 for C=6, PE=2, N=4.
  function automatic logic [ADDR_W-1:0] exp_addr(input int ch, input int ix);
    return ADDR_W'((ch / 2) * 32 + (ch % 2) * 16 + ix);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an output with empty expectation queue, required none, cycle %0d", nm, cyc);
  endtask

  // Records accepts for the edge about to happen, then advances one cycle.
  task automatic tick();
    wr_t w;
    if (bus.ld_vld && bus.ld_rdy) begin
      w.a = exp_addr(tb_pos / TPC, tb_pos % TPC);
      w.d = bus.ld_dat;
      exp_wr.push_back(w);
      tb_pos++;
    end
    if (bus.rb_vld && bus.rb_rdy) begin
      rb_k++;
      if (int'(bus.rb_cnl) < C && int'(bus.rb_idx) < TPC) begin
        exp_ra.push_back(exp_addr(int'(bus.rb_cnl), int'(bus.rb_idx)));
        exp_rd.push_back(val(int'(bus.rb_cnl) * TPC + int'(bus.rb_idx)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic   acc_prev, ld_done_prev, hold_prev;
  logic   wr_now;
  logic [K-1:0] hold_dat;
  wr_t    e;
  always @(negedge clk) begin
    if (rst) begin
      acc_prev     = 1'b0;
      ld_done_prev = 1'b0;
      hold_prev    = 1'b0;
    end else begin
      wr_now = bus.cfg_en && bus.cfg_we;
      if (wr_now || acc_prev) chk("wr_follows_accept", int'(wr_now), int'(acc_prev));
      acc_prev = bus.ld_vld && bus.ld_rdy;
      if (wr_now) begin
        if (wr_count == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_count++;
        if (bus.cfg_a == 7'h35) seen35 = int'(bus.cfg_d);
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", int'(bus.cfg_a), int'(e.a));
          chk("wr_data", int'(bus.cfg_d), int'(e.d));
        end
      end
      if (bus.cfg_en && !bus.cfg_we) begin
        rd_issued++;
        if (exp_ra.size() == 0) fail_now("unexpected_read");
        else chk("rd_addr", int'(bus.cfg_a), int'(exp_ra.pop_front()));
      end
      if (bus.cfg_rack) begin
        rack_cnt++;
        last_rack_cyc = cyc;
      end
      if (hold_prev) begin
        chk("rd_vld_hold", int'(bus.rd_vld), 1);
        chk("rd_dat_hold", int'(bus.rd_dat), int'(hold_dat));
      end
      hold_prev = bus.rd_vld && !bus.rd_rdy;
      hold_dat  = bus.rd_dat;
      if (bus.rd_vld && bus.rd_rdy) begin
        pop_cnt++;
        if (exp_rd.size() == 0) fail_now("unexpected_response");
        else chk("rd_data", int'(bus.rd_dat), int'(exp_rd.pop_front()));
      end
      if (bus.ld_done && !ld_done_prev) ld_done_rise_cyc = cyc;
      ld_done_prev = bus.ld_done;
    end
  end

  int rch[12] = '{0, 5, 3, 1, 2, 4, 5, 0, 3, 2, 1, 4};
  int rix[12] = '{0, 14, 5, 7, 1, 13, 0, 14, 9, 2, 11, 6};

  task automatic full_load();
    tb_pos   = 0;
    wr_count = 0;
    bus.ld_vld = 1'b1;
    for (int g = 0; g < 200 && tb_pos < NTH; g++) begin
      bus.ld_dat = val(tb_pos);
      tick();
    end
    bus.ld_vld = 1'b0;
    chk("load_accepts", tb_pos, NTH);
    repeat (4) tick();
  endtask

  task automatic drive_rb(input int k);
    bus.rb_vld = (k < 12);
    bus.rb_cnl = CNL_W'(rch[k % 12]);
    bus.rb_idx = N'(rix[k % 12]);
  endtask

  initial begin
    int iss, pops, rack_base, rise;
    rst = 1'b1;
    bus.reload = 1'b0; bus.ld_vld = 1'b0; bus.ld_dat = '0;
    bus.rb_vld = 1'b0; bus.rb_cnl = '0; bus.rb_idx = '0; bus.rd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_en", int'(bus.cfg_en), 0);
    chk("rst_cfg_we", int'(bus.cfg_we), 0);
    chk("rst_cfg_a", int'(bus.cfg_a), 0);
    chk("rst_cfg_d", int'(bus.cfg_d), 0);
    chk("rst_ld_done", int'(bus.ld_done), 0);
    chk("rst_ld_err", int'(bus.ld_err), 0);
    chk("rst_rd_vld", int'(bus.rd_vld), 0);
    chk("rst_rb_rdy", int'(bus.rb_rdy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ld_rdy_after_release", int'(bus.ld_rdy), 1);
    chk("rb_rdy_in_load", int'(bus.rb_rdy), 0);

    // Full load with ld_vld held high.
    full_load();
    chk("full_write_count", wr_count, NTH);
    chk("full_write_span", last_wr_cyc - first_wr_cyc, NTH - 1);
    chk("ld_done_after_last_write", ld_done_rise_cyc - last_wr_cyc, 1);
    chk("ch3_idx5_at_0x35", seen35, int'(val(3 * TPC + 5)));
    chk("ld_rdy_in_run", int'(bus.ld_rdy), 0);
    chk("ld_done_in_run", int'(bus.ld_done), 1);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rb_rdy_in_run", int'(bus.rb_rdy), 1);

    // Credit limit with the response side stalled.
    bus.rd_rdy = 1'b0;
    rb_k = 0;
    rd_issued = 0;
    for (int g = 0; g < 20; g++) begin
      drive_rb(rb_k);
      tick();
    end
    chk("credit_limited_issues", rd_issued, RB_DEPTH);
    chk("rb_rdy_when_full", int'(bus.rb_rdy), 0);
    chk("rd_vld_buffered", int'(bus.rd_vld), 1);
    chk("rd_dat_head", int'(bus.rd_dat), int'(val(rch[0] * TPC + rix[0])));
    bus.rd_rdy = 1'b1;
    for (int g = 0; g < 200 && rb_k < 12; g++) begin
      drive_rb(rb_k);
      tick();
    end
    bus.rb_vld = 1'b0;
    for (int g = 0; g < 50 && exp_rd.size() > 0; g++) tick();
    chk("readback_all_returned", exp_rd.size(), 0);
    chk("readback_issued", rd_issued, 12);
    chk("rb_rdy_credits_back", int'(bus.rb_rdy), 1);

    // Out-of-range requests are consumed silently.
    iss = rd_issued;
    pops = pop_cnt;
    rb_k = 0;
    bus.rb_vld = 1'b1; bus.rb_cnl = 3'd6; bus.rb_idx = 4'd0;
    for (int g = 0; g < 10 && rb_k < 1; g++) tick();
    chk("oor_cnl_consumed", rb_k, 1);
    bus.rb_cnl = 3'd0; bus.rb_idx = 4'd15;
    for (int g = 0; g < 10 && rb_k < 2; g++) tick();
    bus.rb_vld = 1'b0;
    chk("oor_idx_consumed", rb_k, 2);
    repeat (8) tick();
    chk("oor_no_cfg_read", rd_issued, iss);
    chk("oor_no_response", pop_cnt, pops);
    chk("oor_rd_vld", int'(bus.rd_vld), 0);

    // Reload with two reads outstanding.
    rb_k = 0;
    rack_base = rack_cnt;
    for (int g = 0; g < 10 && rb_k < 2; g++) begin
      drive_rb(rb_k + 2);
      tick();
    end
    bus.rb_vld = 1'b0;
    chk("ld_done_before_reload", int'(bus.ld_done), 1);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("reads_in_flight_at_reload", rack_cnt - rack_base, 0);
    rise = -1;
    for (int g = 0; g < 40; g++) begin
      if (bus.ld_rdy) begin
        rise = cyc;
        break;
      end
      tick();
    end
    chk("drain_saw_both_racks", rack_cnt - rack_base, 2);
    chk("load_after_last_rack", int'(rise > last_rack_cyc), 1);
    chk("ld_done_drops", int'(bus.ld_done), 0);
    repeat (3) tick();
    chk("drain_responses_delivered", exp_rd.size(), 0);

    // Throttled load, ld_vld low about 1 cycle in 7.
    tb_pos = 0;
    wr_count = 0;
    for (int g = 0; g < 400 && tb_pos < NTH; g++) begin
      bus.ld_vld = ($urandom_range(0, 6) != 0);
      bus.ld_dat = val(tb_pos);
      tick();
    end
    bus.ld_vld = 1'b0;
    repeat (4) tick();
    chk("throttled_write_count", wr_count, NTH);
    chk("throttled_queue_drained", exp_wr.size(), 0);
    chk("throttled_ld_done", int'(bus.ld_done), 1);

    // Readback with a randomly stalling consumer.
    rb_k = 0;
    for (int g = 0; g < 200 && rb_k < 6; g++) begin
      drive_rb(rb_k + 6);
      bus.rd_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    bus.rb_vld = 1'b0;
    bus.rd_rdy = 1'b1;
    for (int g = 0; g < 50 && exp_rd.size() > 0; g++) tick();
    chk("stalled_readback_returned", exp_rd.size(), 0);

`ifdef THRESHOLDING_CFG_ORDER_CHECK_EN
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    for (int g = 0; g < 20 && !bus.ld_rdy; g++) tick();
    tb_pos = 0;
    bus.ld_vld = 1'b1;
    bus.ld_dat = 10'd5;
    for (int g = 0; g < 10 && tb_pos < 1; g++) tick();
    bus.ld_dat = 10'd3;
    for (int g = 0; g < 10 && tb_pos < 2; g++) tick();
    bus.ld_vld = 1'b0;
    repeat (2) tick();
    chk("ld_err_after_decrease", int'(bus.ld_err), 1);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    chk("ld_err_cleared_by_reload", int'(bus.ld_err), 0);
    full_load();
    chk("ld_err_sorted_load", int'(bus.ld_err), 0);
    chk("ld_done_sorted_load", int'(bus.ld_done), 1);
    chk("sorted_queue_drained", exp_wr.size(), 0);
`else
    chk("ld_err_tied_low", int'(bus.ld_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/thresholding_cfg_loader.md
Name: thresholding_cfg_loader

Overview:
- Configuration initiator for the thresholding core's cfg port (cfg_en/cfg_we/cfg_a/cfg_d, cfg_rack/cfg_q).
- Accepts a flat stream of threshold values and issues sequential writes covering all C*(2^N-1) entries.
- Afterwards serves random-access readback requests with credit-limited outstanding reads and an in-order response buffer.
- Sits between the host/weight-stream side and a thresholding instance with USE_CONFIG=1.

Parameters:
K, 10, threshold/data width
N, 4, output precision; 2^N-1 thresholds per channel
C, 6, channel count
PE, 2, processing elements; CF=C/PE, C divisible by PE
SIGNED, 0, thresholds are signed
FPARG, 0, thresholds are fp bit patterns; only meaningful with SIGNED
RB_DEPTH, 4, response FIFO depth = maximum reads in flight plus buffered responses (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reload  in  1  pulse; restart full threshold load
ld_vld  in  1  load stream valid
ld_rdy  out  1  load stream ready
ld_dat  in  K  threshold; channel-major, index-minor order
ld_done  out  1  all thresholds written
ld_err  out  1  sticky ordering error (optional feature)
rb_vld  in  1  readback request valid
rb_rdy  out  1  readback request ready
rb_cnl  in  $clog2(C)  requested channel
rb_idx  in  N  requested threshold index
rd_vld  out  1  readback response valid
rd_rdy  in  1  readback response ready
rd_dat  out  K  readback value
cfg_en  out  1  cfg access enable
cfg_we  out  1  cfg write enable
cfg_a  out  ADDR_W  cfg address; ADDR_W=N+$clog2(PE)+$clog2(CF)
cfg_d  out  K  cfg write data
cfg_rack  in  1  read acknowledge, one-cycle pulse, in order
cfg_q  in  K  read data, qualified by cfg_rack

Behaviour:
- Address format: cfg_a = {cf, pe, idx}.
  - cf = cnl/PE, pe = cnl%PE.
  - A field is omitted when its width is 0 (PE==1 or CF==1).
- All cfg_* outputs are registered.
- Reset values:
  - cfg_en=0, cfg_we=0, cfg_a=0, cfg_d=0.
  - ld_done=0, ld_err=0, rd_vld=0, rb_rdy=0.
  - State LOAD; counters, credit count and FIFO all cleared.
- ld_rdy=1 exactly in LOAD after reset release.
- States:
  - LOAD:
    - ld_vld&&ld_rdy in cycle n -> cfg_en=1, cfg_we=1, cfg_a=current address, cfg_d=ld_dat in cycle n+1.
    - No accept -> cfg_en=0 next cycle.
    - Index counter wraps at 2^N-1 into the channel counter.
    - The final (C*(2^N-1))th write moves the block to RUN; ld_rdy drops the cycle after that accept.
  - RUN:
    - ld_done=1.
    - rb_rdy = (credits < RB_DEPTH), where credits = reads in flight + FIFO occupancy.
    - Accepted request in cycle n -> cfg_en=1, cfg_we=0, cfg_a formed from rb_cnl/rb_idx in cycle n+1.
  - DRAIN:
    - Entered on reload in RUN; rb_rdy=0.
    - Waits until reads in flight == 0, then enters LOAD with ld_done=0 and counters cleared.
    - The FIFO keeps draining to rd_* during and after DRAIN.
- reload in LOAD restarts the counters at 0 next cycle. reload in DRAIN is ignored.
- Credits update:
  - +1 on read issue; -1 on rd_vld&&rd_rdy.
  - Issue and pop in the same cycle leave credits unchanged.
- Reads in flight:
  - +1 on issue, -1 on cfg_rack.
  - cfg_rack with 0 reads in flight is dropped.
- Response FIFO:
  - cfg_rack pushes cfg_q.
  - The credit limit guarantees no overflow, including a push and pop in the same cycle while full.
  - rd_vld/rd_dat are taken from the FIFO head; rd_dat holds while rd_vld&&!rd_rdy.
- Out-of-range requests (rb_cnl>=C or rb_idx==2^N-1):
  - Consumed (rb_rdy honoured); no cfg access and no response.
- Reset mid-operation discards in-flight reads and FIFO contents; the target is reset by the same rst.
- Target read latency is arbitrary but >=1 cycle, with responses in issue order.

Optional Feature:
- Macro: THRESHOLDING_CFG_ORDER_CHECK_EN.
- Defined:
  - Each loaded threshold is compared with the previous one in the same channel under the order key.
  - Order key: unsigned value; SIGNED flips the MSB; with FPARG, negative values also invert bits K-2:0.
  - A decrease sets ld_err sticky; it clears only on rst or on the next accepted reload.
  - Writes proceed regardless.
- Undefined: ld_err tied 0 and no comparator logic.

Test Plan:
- Full load, C=6, PE=2, N=4, ld_vld held high:
  - Exactly 90 writes on consecutive cycles.
  - Channel 3 idx 5 appears at cfg_a=0x35.
  - ld_done rises one cycle after the last write.
- Throttled load, ld_vld random 1/7 low:
  - cfg_en pulses only the cycle after an accept.
  - cfg_d matches the stream order; no extra writes.
- Target read latency 3, rb_vld always high, rd_rdy held low:
  - Exactly 4 reads issued, then rb_rdy=0.
  - Raising rd_rdy returns 4 values in order and reads resume.
- Out-of-range rb_cnl=6 or rb_idx=15: request consumed, cfg_en stays 0, no rd_vld.
- reload asserted with 2 reads in flight:
  - Both responses are still delivered.
  - LOAD is entered only after the second cfg_rack; ld_done drops.
- With THRESHOLDING_CFG_ORDER_CHECK_EN, unsigned, channel 0 loaded as 5 then 3: ld_err=1 after the second write; a fresh sorted reload clears it.
